// File: rtl/io_responder.sv
// Memory-mapped I/O responder: byte TX FIFO feeding a UART 8N1 transmitter, status reads,
// sticky program-end flag. Optional macro IO_CYCLE_COUNTER_EN adds a readable 32-bit cycle counter.
module io_responder #(
    parameter int FIFO_AW      = 4,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       en_in,
    input  logic       wr_in,
    input  logic [2:0] a_in,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic       io_buffer_full,
    output logic       program_finish,
    output logic       tx
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e             state_q;
    logic [7:0]         shift_q;
    logic [CW-1:0]      baud_q;
    logic [2:0]         bit_q;
    logic               tx_q;

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [FIFO_AW:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d, pf_q, pf_d;
    logic [7:0]         dout_q, dout_d;
    logic [7:0]         cyc_byte;

    logic push_req, fifo_empty, fifo_full, pop, push, tx_busy;

    assign push_req   = en_in & wr_in & (a_in == 3'd0);
    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == (FIFO_AW+1)'(DEPTH));
    assign pop        = (state_q == IDLE) & ~fifo_empty;
    // The transmitter's pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign push       = push_req & (~fifo_full | pop);
    assign tx_busy    = (state_q != IDLE);

    assign io_buffer_full = (cnt_q >= (FIFO_AW+1)'(DEPTH - 2));
    assign program_finish = pf_q;
    assign d_out          = dout_q;
    assign tx             = tx_q;

`ifdef IO_CYCLE_COUNTER_EN
    logic [31:0] cyc_q;
    always_ff @(posedge clk_in) begin
        if (rst_in) cyc_q <= '0;
        else        cyc_q <= cyc_q + 32'd1;
    end
    assign cyc_byte = cyc_q[{a_in[1:0], 3'b000} +: 8];
`else
    assign cyc_byte = 8'h00;
`endif

    always_comb begin
        wptr_d = wptr_q + FIFO_AW'(push);
        rptr_d = rptr_q + FIFO_AW'(pop);
        cnt_d  = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        ovf_d  = ovf_q | (push_req & fifo_full & ~pop);
        pf_d   = pf_q | (en_in & wr_in & (a_in == 3'd4));
        dout_d = dout_q;
        if (en_in && !wr_in) begin
            case (a_in)
                3'd0:                dout_d = {5'b0, ovf_q, fifo_empty, tx_busy};
                3'd1, 3'd2, 3'd3:    dout_d = 8'h00;
                default:             dout_d = cyc_byte;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            pf_q   <= 1'b0;
            dout_q <= 8'h00;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            pf_q   <= pf_d;
            dout_q <= dout_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push && !rst_in) mem_q[wptr_q] <= d_in;
    end

    // tx is registered: the level for each bit is loaded on the edge that enters that bit.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            shift_q <= 8'h00;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    baud_q <= '0;
                    if (pop) begin
                        shift_q <= mem_q[rptr_q];
                        state_q <= START;
                        tx_q    <= 1'b0;
                    end
                end
                START: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q  <= '0;
                        bit_q   <= 3'd0;
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= shift_q[bit_q + 3'd1];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q  <= '0;
                        state_q <= IDLE;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_io_responder.sv
// Bench for io_responder (CLKS_PER_BIT=4, FIFO_AW=2): directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the FIFO, frame timing and read data.
module tb_io_responder;
    localparam int CPB   = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       en_in  = 1'b0;
    logic       wr_in  = 1'b0;
    logic [2:0] a_in   = 3'd0;
    logic [7:0] d_in   = 8'h00;
    logic [7:0] d_out;
    logic       io_buffer_full, program_finish, tx;

    always #5 clk_in = ~clk_in;

    io_responder #(.FIFO_AW(AW), .CLKS_PER_BIT(CPB)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .en_in(en_in), .wr_in(wr_in), .a_in(a_in), .d_in(d_in),
        .d_out(d_out), .io_buffer_full(io_buffer_full), .program_finish(program_finish), .tx(tx)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: byte queue, frame countdown after each pop, sticky flags.
    byte unsigned q[$];
    logic [7:0]   m_cur = 8'h00;
    logic [7:0]   m_dout = 8'h00;
    bit           m_ovf = 0, m_pf = 0;
    int           m_rem = 0;
    int unsigned  m_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame bit position b: 0 = start, 1..8 = data LSB first, 9 = stop.
    function automatic logic m_tx();
        int b;
        if (m_rem == 0) return 1'b1;
        b = (FRAME - m_rem) / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_cur[b-1];
    endfunction

    task automatic tick();
        bit pop, full_pre;
        logic [31:0] c;
        @(posedge clk_in);
        if (rst_in) begin
            q.delete();
            m_ovf = 0; m_pf = 0; m_rem = 0; m_dout = 8'h00; m_cyc = 0;
        end else begin
            pop      = (m_rem == 0) && (q.size() != 0);
            full_pre = (q.size() == DEPTH);
            if (en_in && !wr_in) begin
                c = m_cyc;
                if (a_in == 3'd0)     m_dout = {5'b0, m_ovf, q.size() == 0, m_rem > 0};
                else if (a_in < 3'd4) m_dout = 8'h00;
                else begin
`ifdef IO_CYCLE_COUNTER_EN
                    m_dout = 8'((c >> (8 * int'(a_in[1:0]))) & 32'hff);
`else
                    m_dout = 8'h00;
`endif
                end
            end
            if (pop) begin
                m_cur = q.pop_front();
                m_rem = FRAME;
            end else if (m_rem > 0) begin
                m_rem--;
            end
            if (en_in && wr_in && a_in == 3'd0) begin
                if (!full_pre || pop) q.push_back(d_in);
                else m_ovf = 1;
            end
            if (en_in && wr_in && a_in == 3'd4) m_pf = 1;
            m_cyc++;
        end
        @(negedge clk_in);
        chk("tx", tx, m_tx());
        chk("io_buffer_full", io_buffer_full, q.size() >= DEPTH - 2);
        chk("program_finish", program_finish, m_pf);
        chk("d_out", d_out, m_dout);
    endtask

    task automatic drive(input logic en, input logic wr, input logic [2:0] a, input logic [7:0] d);
        en_in = en; wr_in = wr; a_in = a; d_in = d;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 3'd0, 8'h00);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_drained();
        int k;
        drive(0, 0, 3'd0, 8'h00);
        k = 0;
        while ((m_rem != 0 || q.size() != 0) && k < 500) begin tick(); k++; end
        chk("drain_timeout", k < 500, 1);
    endtask

    task automatic do_reset(input int n);
        drive(0, 0, 3'd0, 8'h00);
        rst_in = 1'b1;
        for (int i = 0; i < n; i++) tick();
        rst_in = 1'b0;
    endtask

    logic [7:0] v1, v2;
    int k;

    initial begin
        // Reset state, with bus activity that must be ignored
        rst_in = 1'b1;
        drive(1, 1, 3'd4, 8'h55);
        tick(); tick();
        drive(1, 1, 3'd0, 8'hAA);
        tick();
        rst_in = 1'b0;
        drive(0, 0, 3'd0, 8'h00);
        chk("rst_tx", tx, 1);
        chk("rst_dout", d_out, 8'h00);
        chk("rst_pf", program_finish, 0);
        idle(2);

        // Single byte 8'h41: frame starts within 2 cycles
        drive(1, 1, 3'd0, 8'h41);
        tick();
        drive(0, 0, 3'd0, 8'h00);
        tick();
        chk("frame_start", tx, 0);
        idle(45);

        // Writes to other ports are ignored, reads 1..3 return zero
        drive(1, 1, 3'd1, 8'h12); tick();
        drive(1, 1, 3'd7, 8'h34); tick();
        drive(1, 0, 3'd2, 8'h00); tick();
        chk("rd_a2", d_out, 8'h00);
        drive(1, 0, 3'd0, 8'h00); tick();
        chk("status_idle", d_out, 8'h02);
        idle(3);

        // Fill while transmitting, then push on the exact cycle the FSM pops from a full FIFO
        for (int i = 0; i < 5; i++) begin drive(1, 1, 3'd0, 8'(8'h10 + i)); tick(); end
        drive(0, 0, 3'd0, 8'h00);
        chk("full_flag", io_buffer_full, 1);
        k = 0;
        while (m_rem != 0 && k < 100) begin tick(); k++; end
        chk("pop_wait_timeout", k < 100, 1);
        drive(1, 1, 3'd0, 8'hC3); tick();
        chk("simul_count", q.size(), DEPTH);
        drive(1, 0, 3'd0, 8'h00); tick();
        chk("simul_no_ovf", d_out[2], 0);
        wait_drained();

        // Overflow: six back-to-back writes from idle
        do_reset(1);
        for (int i = 0; i < 6; i++) begin drive(1, 1, 3'd0, 8'(8'hA0 + i)); tick(); end
        drive(1, 0, 3'd0, 8'h00); tick();
        chk("ovf_bit", d_out[2], 1);
        wait_drained();

        // Program finish is sticky until reset
        drive(1, 1, 3'd4, 8'h00); tick();
        chk("pf_set", program_finish, 1);
        idle(100);
        chk("pf_hold", program_finish, 1);
        do_reset(1);
        chk("pf_clr", program_finish, 0);

        // Reset in the middle of data bit 3
        drive(1, 1, 3'd0, 8'hF5); tick();
        drive(0, 0, 3'd0, 8'h00);
        k = 0;
        while (!(m_rem > 0 && (FRAME - m_rem) / CPB == 4) && k < 50) begin tick(); k++; end
        chk("bit3_timeout", k < 50, 1);
        tick();
        do_reset(1);
        chk("abort_tx", tx, 1);
        drive(1, 0, 3'd0, 8'h00); tick();
        chk("abort_status", d_out, 8'h02);

        // Cycle counter reads 10 cycles apart
        idle(7);
        drive(1, 0, 3'd4, 8'h00); tick(); v1 = d_out;
        idle(9);
        drive(1, 0, 3'd4, 8'h00); tick(); v2 = d_out;
`ifdef IO_CYCLE_COUNTER_EN
        chk("cyc_delta", 8'(v2 - v1), 8'd10);
`else
        chk("cyc_off1", v1, 8'h00);
        chk("cyc_off2", v2, 8'h00);
`endif
        drive(1, 0, 3'd5, 8'h00); tick();
        drive(1, 0, 3'd7, 8'h00); tick();

        // Random traffic, occasional reset
        for (int i = 0; i < 1500; i++) begin
            rst_in = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 2) == 0) drive(0, 0, 3'd0, 8'h00);
            else drive(1, $urandom_range(0, 1), ($urandom_range(0, 1) == 1) ? 3'd0 : 3'($urandom_range(0, 7)),
                       8'($urandom));
            tick();
        end
        rst_in = 1'b0;
        wait_drained();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
